// File: rtl/serial_word_transmitter_pkg.sv
// rtl/serial_word_transmitter_pkg.sv - shared types and sizing helpers for the serial word link
package serial_word_transmitter_pkg;

    localparam int DEFAULT_WIDTH = 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_GAP   = 2'd2
    } tx_state_e;

    // Counter width for a modulus n, never narrower than one bit.
    function automatic int cnt_width(input int n);
        return ($clog2(n) > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/word_holding_buffer.sv
// rtl/word_holding_buffer.sv - one-entry valid/ready holding register with drain strobe
module word_holding_buffer #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             drain,
    output logic [WIDTH-1:0] buf_data,
    output logic             buf_full
);

    logic [WIDTH-1:0] data_q, data_d;
    logic             full_q, full_d;
    logic             capture;

    // Ready is gated by reset so nothing is offered acceptance while held in reset.
    assign in_ready = reset & ~full_q;
    assign capture  = in_valid & in_ready;

    always_comb begin
        data_d = data_q;
        full_d = full_q;
        if (capture) begin
            data_d = in_data;
            full_d = 1'b1;
        end else if (drain) begin
            full_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            data_q <= '0;
            full_q <= 1'b0;
        end else begin
            data_q <= data_d;
            full_q <= full_d;
        end
    end

    assign buf_data = data_q;
    assign buf_full = full_q;

endmodule

// File: rtl/serial_word_transmitter.sv
// rtl/serial_word_transmitter.sv - parallel-in, MSB-first serial-out transmitter with hold and inter-word gap
module serial_word_transmitter
    import serial_word_transmitter_pkg::*;
#(
    parameter int WIDTH      = DEFAULT_WIDTH,
    parameter int GAP_CYCLES = 0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             hold,
    output logic             data,
    output logic             shift_enable,
    output logic             word_done,
    output logic             busy
);

    localparam int BW = cnt_width(WIDTH);
    localparam int GW = cnt_width(GAP_CYCLES);
    localparam logic [BW-1:0] BIT_LAST = BW'(WIDTH - 1);
    localparam logic [GW-1:0] GAP_LAST = GW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

    tx_state_e        state_q;
    logic [WIDTH-1:0] sr_q;
    logic [BW-1:0]    bit_cnt_q;
    logic [GW-1:0]    gap_cnt_q;

    logic [WIDTH-1:0] buf_data;
    logic             buf_full;
    logic             drain;
    logic             shifting;
    logic             shift_en;
    logic             last_bit;
    logic             gap_end;

    assign shifting = (state_q == ST_SHIFT);
    assign shift_en = shifting & ~hold;
    assign last_bit = shift_en & (bit_cnt_q == BIT_LAST);
    assign gap_end  = (state_q == ST_GAP) & (gap_cnt_q == GAP_LAST);

    // Every edge on which the FSM reloads the shift register empties the buffer.
    assign drain = buf_full & ((state_q == ST_IDLE) | (last_bit & (GAP_CYCLES == 0)) | gap_end);

    word_holding_buffer #(
        .WIDTH(WIDTH)
    ) u_buf (
        .clk     (clk),
        .reset   (reset),
        .in_data (in_data),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .drain   (drain),
        .buf_data(buf_data),
        .buf_full(buf_full)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= ST_IDLE;
            sr_q      <= '0;
            bit_cnt_q <= '0;
            gap_cnt_q <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (buf_full) begin
                        sr_q      <= buf_data;
                        bit_cnt_q <= '0;
                        state_q   <= ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    if (!hold) begin
                        if (bit_cnt_q != BIT_LAST) begin
                            sr_q      <= sr_q << 1;
                            bit_cnt_q <= bit_cnt_q + BW'(1);
                        end else if (GAP_CYCLES > 0) begin
                            sr_q      <= sr_q << 1;
                            bit_cnt_q <= '0;
                            gap_cnt_q <= '0;
                            state_q   <= ST_GAP;
                        end else if (buf_full) begin
                            sr_q      <= buf_data;
                            bit_cnt_q <= '0;
                        end else begin
                            sr_q      <= sr_q << 1;
                            bit_cnt_q <= '0;
                            state_q   <= ST_IDLE;
                        end
                    end
                end
                ST_GAP: begin
                    if (gap_cnt_q == GAP_LAST) begin
                        gap_cnt_q <= '0;
                        if (buf_full) begin
                            sr_q      <= buf_data;
                            bit_cnt_q <= '0;
                            state_q   <= ST_SHIFT;
                        end else begin
                            state_q   <= ST_IDLE;
                        end
                    end else begin
                        gap_cnt_q <= gap_cnt_q + GW'(1);
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign data         = shifting & sr_q[WIDTH-1];
    assign shift_enable = shift_en;
    assign word_done    = last_bit;
    assign busy         = (state_q != ST_IDLE) | buf_full;

endmodule

// File: tb/tb_serial_word_transmitter.sv
// tb/tb_serial_word_transmitter.sv - randomized self-checking bench with bit-stream reference model
module tb_serial_word_transmitter;

    logic            clk = 1'b0;
    logic            reset;
    logic [1:0][7:0] in_data;
    logic [1:0]      in_valid;
    logic [1:0]      hold_force;
    logic [1:0]      hold_rnd;
    logic [1:0]      hold;
    logic [1:0]      in_ready;
    logic [1:0]      data_o;
    logic [1:0]      se;
    logic [1:0]      wd;
    logic [1:0]      busy;
    logic [1:0][7:0] rx;
    bit              rand_hold;

    always #5 clk = ~clk;

    assign hold = rand_hold ? hold_rnd : hold_force;

    serial_word_transmitter #(.WIDTH(8), .GAP_CYCLES(0)) dut0 (
        .clk(clk), .reset(reset), .in_data(in_data[0]), .in_valid(in_valid[0]),
        .in_ready(in_ready[0]), .hold(hold[0]), .data(data_o[0]),
        .shift_enable(se[0]), .word_done(wd[0]), .busy(busy[0])
    );

    serial_word_transmitter #(.WIDTH(8), .GAP_CYCLES(3)) dut1 (
        .clk(clk), .reset(reset), .in_data(in_data[1]), .in_valid(in_valid[1]),
        .in_ready(in_ready[1]), .hold(hold[1]), .data(data_o[1]),
        .shift_enable(se[1]), .word_done(wd[1]), .busy(busy[1])
    );

    // Looped-back receivers: plain shift registers, no reset.
    always @(posedge clk) begin
        if (se[0]) rx[0] <= {rx[0][6:0], data_o[0]};
        if (se[1]) rx[1] <= {rx[1][6:0], data_o[1]};
    end

    always @(posedge clk) begin
        #3;
        hold_rnd[0] = ($urandom_range(0, 3) == 0);
        hold_rnd[1] = ($urandom_range(0, 3) == 0);
    end

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: queue of accepted words per instance, consumed MSB first.
    logic [7:0] exp_q0[$];
    logic [7:0] exp_q1[$];
    int pos[2];
    int idle_run[2];
    int last_gap[2];
    int se_run[2];
    int max_run[2];

    task automatic monitor_one(input int i);
        logic [7:0] w;
        bit have;
        have = (i == 0) ? (exp_q0.size() != 0) : (exp_q1.size() != 0);
        w = 8'h00;
        if (have) w = (i == 0) ? exp_q0[0] : exp_q1[0];
        if (se[i]) begin
            se_run[i]++;
            if (se_run[i] > max_run[i]) max_run[i] = se_run[i];
            if (idle_run[i] >= 0) begin
                last_gap[i] = idle_run[i];
                if (i == 1) check("gap_min", 32'(idle_run[i] >= 3), 1);
            end
            idle_run[i] = -1;
            if (!have) begin
                check("spurious_bit", 1, 0);
            end else begin
                check("bit", data_o[i], w[7 - pos[i]]);
                check("word_done", wd[i], pos[i] == 7);
                if (pos[i] == 7) begin
                    check("rx_word", {rx[i][6:0], data_o[i]}, w);
                    if (i == 0) void'(exp_q0.pop_front());
                    else        void'(exp_q1.pop_front());
                    pos[i] = 0;
                    idle_run[i] = 0;
                end else begin
                    pos[i]++;
                end
            end
        end else begin
            se_run[i] = 0;
            check("wd_without_shift", wd[i], 0);
            if (idle_run[i] >= 0) idle_run[i]++;
        end
    endtask

    always @(negedge clk) begin
        if (reset) begin
            monitor_one(0);
            monitor_one(1);
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic send(input int i, input logic [7:0] w, output int waited);
        bit ok;
        ok = 0;
        waited = 0;
        in_data[i]  = w;
        in_valid[i] = 1'b1;
        while (waited < 200) begin
            @(negedge clk);
            if (in_ready[i]) begin
                ok = 1;
                break;
            end
            waited++;
        end
        if (!ok) check("accept_timeout", 0, 1);
        else if (i == 0) exp_q0.push_back(w);
        else exp_q1.push_back(w);
        @(posedge clk);
        #2;
        in_valid[i] = 1'b0;
        in_data[i]  = 8'($urandom);
    endtask

    task automatic wait_idle(input int i);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (n < 400 && (busy[i] || ((i == 0) ? exp_q0.size() : exp_q1.size()) != 0));
        check("drain_timeout", 32'(n < 400), 1);
        tick();
    endtask

    initial begin
        int w0, s, cnt;
        logic [9:0] sev, wdv;
        reset = 1'b0;
        in_data = '0;
        in_valid = '0;
        hold_force = '0;
        rand_hold = 0;
        for (int i = 0; i < 2; i++) begin
            pos[i] = 0; idle_run[i] = -1; last_gap[i] = -1; se_run[i] = 0; max_run[i] = 0;
        end

        repeat (3) @(negedge clk);
        check("rst_in_ready", in_ready, 2'b00);
        check("rst_busy", busy, 2'b00);
        check("rst_se", se, 2'b00);
        check("rst_data", data_o, 2'b00);
        check("rst_wd", wd, 2'b00);
        tick();
        reset = 1'b1;
        @(negedge clk);
        check("post_rst_in_ready", in_ready, 2'b11);

        // Single word timing
        tick();
        send(0, 8'hA5, w0);
        sev = '0; wdv = '0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            sev[k] = se[0];
            wdv[k] = wd[0];
            if (k == 0) begin
                check("single_busy_s0", busy[0], 1);
                check("single_ready_s0", in_ready[0], 0);
            end
            if (k == 1) check("single_msb", data_o[0], 1);
        end
        check("single_se_pattern", sev, 10'b01_1111_1110);
        check("single_wd_pattern", wdv, 10'b01_0000_0000);
        check("single_busy_fall", busy[0], 0);
        check("single_ready_back", in_ready[0], 1);
        check("single_rx", rx[0], 8'hA5);
        tick();

        // Back-to-back with no gap
        max_run[0] = 0;
        send(0, 8'h3C, w0);
        send(0, 8'hFF, w0);
        check("b2b_ready_low_cycles", w0, 1);
        wait_idle(0);
        check("b2b_se_run", max_run[0], 16);
        check("b2b_gap", last_gap[0], 0);
        check("b2b_rx", rx[0], 8'hFF);

        // Mandatory gap of 3
        send(1, 8'h81, w0);
        send(1, 8'h7E, w0);
        wait_idle(1);
        check("gap_len", last_gap[1], 3);
        check("gap_rx", rx[1], 8'h7E);

        // Hold for two cycles after the 3rd bit of 0x96
        send(0, 8'h96, w0);
        s = -1; cnt = 0;
        while (cnt < 3 && s < 40) begin
            @(negedge clk);
            s++;
            if (se[0]) cnt++;
        end
        check("hold_third_bit_cycle", s, 3);
        @(posedge clk); #2;
        hold_force[0] = 1'b1;
        repeat (2) begin
            @(negedge clk);
            s++;
            check("hold_se", se[0], 0);
            check("hold_data", data_o[0], 1);
        end
        @(posedge clk); #2;
        hold_force[0] = 1'b0;
        do begin
            @(negedge clk);
            s++;
        end while (!wd[0] && s < 40);
        check("hold_done_cycle", s, 10);
        wait_idle(0);
        check("hold_rx", rx[0], 8'h96);

        // Reset mid-word with a second word buffered
        send(0, 8'hF0, w0);
        send(0, 8'h0F, w0);
        cnt = 0; s = 0;
        while (cnt < 4 && s < 40) begin
            @(negedge clk);
            s++;
            if (se[0]) cnt++;
        end
        check("midrst_reached_bit4", cnt, 4);
        @(posedge clk); #2;
        reset = 1'b0;
        #1;
        check("midrst_se", se[0], 0);
        check("midrst_data", data_o[0], 0);
        check("midrst_wd", wd[0], 0);
        check("midrst_busy", busy[0], 0);
        check("midrst_ready", in_ready[0], 0);
        exp_q0.delete();
        pos[0] = 0;
        repeat (2) @(negedge clk);
        tick();
        reset = 1'b1;
        cnt = 0;
        repeat (6) begin
            @(negedge clk);
            if (se[0] || busy[0]) cnt++;
        end
        check("midrst_quiet", cnt, 0);
        tick();
        send(0, 8'h55, w0);
        wait_idle(0);
        check("midrst_rx_55", rx[0], 8'h55);

        // Randomized words with random hold on both instances
        rand_hold = 1;
        for (int i = 0; i < 2; i++) begin
            for (int n = 0; n < 25; n++) begin
                repeat ($urandom_range(0, 3)) tick();
                send(i, 8'($urandom), w0);
            end
        end
        rand_hold = 0;
        tick();
        wait_idle(0);
        wait_idle(1);
        check("rand_q0_empty", exp_q0.size(), 0);
        check("rand_q1_empty", exp_q1.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
